// File: rtl/kernel_prune_stream_if.sv
// kernel_prune_stream_if: weight-in / packed-kernel-out handshake bundle.
interface kernel_prune_stream_if #(
    parameter int DATA_W = 8,
    parameter int TAPS   = 9
);
    localparam int CNT_W = $clog2(TAPS + 1);
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_W-1:0]      in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [TAPS*DATA_W-1:0] out_kernel;
    logic [TAPS-1:0]        out_mask;
    logic [CNT_W-1:0]       out_nz;
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_kernel, out_mask, out_nz
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_kernel, out_mask, out_nz
    );
endinterface

// File: rtl/kernel_prune_stream.sv
// kernel_prune_stream: zeroes weights below a threshold and packs TAPS of them per kernel; statistics enabled by KPRUNE_STATS_EN.
module kernel_prune_stream #(
    parameter int DATA_W = 8,
    parameter int TAPS   = 9,
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prune_en,
    input  logic [DATA_W-1:0] thresh,
    kernel_prune_stream_if.slave s
`ifdef KPRUNE_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_kernels,
    output logic [STAT_W-1:0] stat_pruned
`endif
);
    localparam int CNT_W = $clog2(TAPS + 1);
    localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    typedef enum logic {FILL, HOLD} state_t;
    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_W-1:0]      thr_q, thr_d;
    logic                   pen_q, pen_d;
    logic [TAPS*DATA_W-1:0] kernel_q, kernel_d;
    logic [TAPS-1:0]        mask_q, mask_d;
    logic [CNT_W-1:0]       nz_q, nz_d;
    logic [CNT_W-1:0]       prc_q, prc_d;
    logic                   fire_in, fire_out, first, last;
    logic [DATA_W-1:0]      eff_thr, w, w_out;
    logic                   eff_pen, kill, nz_bit, pr_bit;
    logic [DATA_W:0]        mag;
    assign s.in_ready   = (state_q == FILL) && !rst;
    assign s.out_valid  = (state_q == HOLD);
    assign s.out_kernel = kernel_q;
    assign s.out_mask   = mask_q;
    assign s.out_nz     = nz_q;
    assign fire_in  = s.in_valid && s.in_ready;
    assign fire_out = s.out_valid && s.out_ready;
    assign first    = (idx_q == '0);
    assign last     = (idx_q == IDX_W'(TAPS - 1));
    // Parameters are taken live on the first weight so that weight already uses them.
    assign eff_thr = first ? thresh : thr_q;
    assign eff_pen = first ? prune_en : pen_q;
    assign w       = s.in_data;
    assign mag     = w[DATA_W-1] ? -{w[DATA_W-1], w} : {1'b0, w};
    assign kill    = eff_pen && (mag < {1'b0, eff_thr});
    assign w_out   = kill ? '0 : w;
    assign nz_bit  = (w_out != '0);
    assign pr_bit  = kill && (w != '0);
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        thr_d    = thr_q;
        pen_d    = pen_q;
        kernel_d = kernel_q;
        mask_d   = mask_q;
        nz_d     = nz_q;
        prc_d    = prc_q;
        if (fire_in) begin
            thr_d    = eff_thr;
            pen_d    = eff_pen;
            kernel_d = {kernel_q[(TAPS-1)*DATA_W-1:0], w_out};
            mask_d   = {mask_q[TAPS-2:0], nz_bit};
            nz_d     = (first ? '0 : nz_q) + CNT_W'(nz_bit);
            prc_d    = (first ? '0 : prc_q) + CNT_W'(pr_bit);
            idx_d    = last ? '0 : idx_q + IDX_W'(1);
            state_d  = last ? HOLD : FILL;
        end
        if (fire_out) state_d = FILL;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FILL;
            idx_q    <= '0;
            thr_q    <= '0;
            pen_q    <= 1'b0;
            kernel_q <= '0;
            mask_q   <= '0;
            nz_q     <= '0;
            prc_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            thr_q    <= thr_d;
            pen_q    <= pen_d;
            kernel_q <= kernel_d;
            mask_q   <= mask_d;
            nz_q     <= nz_d;
            prc_q    <= prc_d;
        end
    end
`ifdef KPRUNE_STATS_EN
    logic [STAT_W-1:0] stat_k_q, stat_k_d, stat_p_q, stat_p_d;
    logic [STAT_W:0]   k_sum, p_sum;
    assign k_sum = {1'b0, stat_k_q} + (STAT_W+1)'(1);
    assign p_sum = {1'b0, stat_p_q} + (STAT_W+1)'(prc_q);
    assign stat_kernels = stat_k_q;
    assign stat_pruned  = stat_p_q;
    always_comb begin
        stat_k_d = stat_clr ? '0 : !fire_out ? stat_k_q : k_sum[STAT_W] ? '1 : k_sum[STAT_W-1:0];
        stat_p_d = stat_clr ? '0 : !fire_out ? stat_p_q : p_sum[STAT_W] ? '1 : p_sum[STAT_W-1:0];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_k_q <= '0;
            stat_p_q <= '0;
        end else begin
            stat_k_q <= stat_k_d;
            stat_p_q <= stat_p_d;
        end
    end
`endif
endmodule
